// File: rtl/udp_pkg.sv
// Shared constants and types for the UDP receive parser.
//   UDP_HDR_LEN   : header size in bytes
//   OFF_*         : big-endian byte offsets of the header fields
//   err_code_e    : error classification reported with done
//   state_e       : parser FSM states
//   idx_w()       : width of a listen-table index (at least 1 bit)
package udp_pkg;

  localparam int unsigned UDP_HDR_LEN = 8;

  localparam logic [2:0] OFF_SRC_HI  = 3'd0;
  localparam logic [2:0] OFF_SRC_LO  = 3'd1;
  localparam logic [2:0] OFF_DST_HI  = 3'd2;
  localparam logic [2:0] OFF_DST_LO  = 3'd3;
  localparam logic [2:0] OFF_LEN_HI  = 3'd4;
  localparam logic [2:0] OFF_LEN_LO  = 3'd5;
  localparam logic [2:0] OFF_CSUM_HI = 3'd6;
  localparam logic [2:0] OFF_CSUM_LO = 3'd7;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrLenBad   = 2'd1,
    ErrTrunc    = 2'd2,
    ErrHdrTrunc = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StDrain,
    StDrop
  } state_e;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udp_port_match.sv
// Combinational destination-port matcher against the listen table.
//   dest_i         : destination port to look up
//   promisc_i      : accept any port
//   listen_en_i    : per-entry enable
//   listen_ports_i : entry i at bits [16i+15:16i]
//   hit_o          : promisc or any enabled entry equals dest_i
//   idx_o          : lowest matching enabled entry, 0 when nothing matches
module udp_port_match
  import udp_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [15:0]                  dest_i,
  input  logic                         promisc_i,
  input  logic [NUM_PORTS-1:0]         listen_en_i,
  input  logic [16*NUM_PORTS-1:0]      listen_ports_i,
  output logic                         hit_o,
  output logic [idx_w(NUM_PORTS)-1:0]  idx_o
);

  localparam int unsigned IdxW = idx_w(NUM_PORTS);

  logic [NUM_PORTS-1:0] entry_hit;
  logic                 found;

  always_comb begin
    entry_hit = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      entry_hit[i] = listen_en_i[i] && (listen_ports_i[16*i +: 16] == dest_i);
    end
  end

  // Ascending scan that latches the first hit gives lowest-index priority.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (entry_hit[i] && !found) begin
        found = 1'b1;
        idx_o = IdxW'(i);
      end
    end
    hit_o = promisc_i || found;
  end

endmodule

// File: rtl/udp_rx_parser.sv
// Byte-serial UDP header parser with listen-table port filter and payload forwarding.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   valid_i, din_i          : input byte stream; a contiguous valid run is one frame
//   promisc_i               : accept every destination port
//   listen_en_i             : per-entry enable of the listen table
//   listen_ports_i          : listen table, entry i at bits [16i+15:16i]
//   source_o .. checksum_o  : latched header fields
//   hdr_done_o              : one-cycle pulse once the header is latched
//   port_hit_o, port_idx_o  : registered match result, valid from hdr_done until next frame
//   pl_valid_o, pl_data_o   : payload bytes, one cycle after acceptance
//   pl_first_o, pl_last_o   : first / last payload byte markers
//   done_o                  : one-cycle pulse when a frame finishes (good or error)
//   err_o, err_code_o       : sticky error flag and code, cleared on next frame start
module udp_rx_parser
  import udp_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MAX_LEN   = 1500
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         valid_i,
  input  logic [7:0]                   din_i,
  input  logic                         promisc_i,
  input  logic [NUM_PORTS-1:0]         listen_en_i,
  input  logic [16*NUM_PORTS-1:0]      listen_ports_i,
  output logic [15:0]                  source_o,
  output logic [15:0]                  dest_o,
  output logic [15:0]                  length_o,
  output logic [15:0]                  checksum_o,
  output logic                         hdr_done_o,
  output logic                         port_hit_o,
  output logic [idx_w(NUM_PORTS)-1:0]  port_idx_o,
  output logic                         pl_valid_o,
  output logic [7:0]                   pl_data_o,
  output logic                         pl_first_o,
  output logic                         pl_last_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [1:0]                   err_code_o
);

  localparam int unsigned IdxW   = idx_w(NUM_PORTS);
  localparam logic [15:0] HdrLen = 16'(UDP_HDR_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  state_e          state_q;
  logic [15:0]     cnt_q;
  logic [7:0]      hi_q;
  logic [15:0]     source_q, dest_q, length_q, checksum_q;
  logic            hdr_done_q, port_hit_q;
  logic [IdxW-1:0] port_idx_q;
  logic            pl_valid_q, pl_first_q, pl_last_q;
  logic [7:0]      pl_data_q;
  logic            done_q, err_q;
  err_code_e       err_code_q;

  logic            match_hit;
  logic [IdxW-1:0] match_idx;
  logic [15:0]     cnt_inc;
  logic            bad_len;

  // dest_q is already loaded (byte 3) when the match is registered at byte 7.
  udp_port_match #(
    .NUM_PORTS (NUM_PORTS)
  ) u_port_match (
    .dest_i         (dest_q),
    .promisc_i      (promisc_i),
    .listen_en_i    (listen_en_i),
    .listen_ports_i (listen_ports_i),
    .hit_o          (match_hit),
    .idx_o          (match_idx)
  );

  assign cnt_inc = cnt_q + 16'd1;
  assign bad_len = (length_q < HdrLen) || (length_q > MaxLen);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      source_q   <= '0;
      dest_q     <= '0;
      length_q   <= '0;
      checksum_q <= '0;
      hdr_done_q <= 1'b0;
      port_hit_q <= 1'b0;
      port_idx_q <= '0;
      pl_valid_q <= 1'b0;
      pl_data_q  <= '0;
      pl_first_q <= 1'b0;
      pl_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      // Pulse outputs default low every cycle.
      hdr_done_q <= 1'b0;
      done_q     <= 1'b0;
      pl_valid_q <= 1'b0;
      pl_first_q <= 1'b0;
      pl_last_q  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            hi_q       <= din_i;
            cnt_q      <= 16'd1;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            port_hit_q <= 1'b0;
            port_idx_q <= '0;
            state_q    <= StHdr;
          end
        end

        StHdr: begin
          if (!valid_i) begin
            err_q      <= 1'b1;
            err_code_q <= ErrHdrTrunc;
            done_q     <= 1'b1;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
            unique case (cnt_q[2:0])
              OFF_SRC_HI, OFF_DST_HI, OFF_LEN_HI, OFF_CSUM_HI: hi_q <= din_i;
              OFF_SRC_LO: source_q <= {hi_q, din_i};
              OFF_DST_LO: dest_q   <= {hi_q, din_i};
              OFF_LEN_LO: length_q <= {hi_q, din_i};
              OFF_CSUM_LO: begin
                checksum_q <= {hi_q, din_i};
                hdr_done_q <= 1'b1;
                port_hit_q <= match_hit;
                port_idx_q <= match_idx;
                if (bad_len) begin
                  err_q      <= 1'b1;
                  err_code_q <= ErrLenBad;
                  done_q     <= 1'b1;
                  state_q    <= StDrop;
                end else if (length_q == HdrLen) begin
                  done_q  <= 1'b1;
                  state_q <= StDrain;
                end else if (!match_hit) begin
                  state_q <= StDrop;
                end else begin
                  state_q <= StPayload;
                end
              end
            endcase
          end
        end

        StPayload: begin
          if (!valid_i) begin
            err_q      <= 1'b1;
            err_code_q <= ErrTrunc;
            done_q     <= 1'b1;
            state_q    <= StIdle;
          end else begin
            pl_valid_q <= 1'b1;
            pl_data_q  <= din_i;
            pl_first_q <= (cnt_q == HdrLen);
            cnt_q      <= cnt_inc;
            // Counter stops here; anything after is padding handled by StDrain.
            if (cnt_inc == length_q) begin
              pl_last_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= StDrain;
            end
          end
        end

        StDrain, StDrop: begin
          if (!valid_i) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign source_o   = source_q;
  assign dest_o     = dest_q;
  assign length_o   = length_q;
  assign checksum_o = checksum_q;
  assign hdr_done_o = hdr_done_q;
  assign port_hit_o = port_hit_q;
  assign port_idx_o = port_idx_q;
  assign pl_valid_o = pl_valid_q;
  assign pl_data_o  = pl_data_q;
  assign pl_first_o = pl_first_q;
  assign pl_last_o  = pl_last_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Self-checking bench for udp_rx_parser: directed cases plus randomized frames,
// checked against a frame-level reference model.
module tb_udp_rx_parser;

  localparam int unsigned NP   = 4;
  localparam int unsigned MAXL = 40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              valid = 1'b0;
  logic [7:0]        din = 8'h00;
  logic              promisc = 1'b0;
  logic [NP-1:0]     listen_en = '0;
  logic [16*NP-1:0]  listen_ports = '0;
  logic [15:0]       source, dest, length, checksum;
  logic              hdr_done, port_hit, pl_valid, pl_first, pl_last, done, err;
  logic [1:0]        port_idx, err_code;
  logic [7:0]        pl_data;

  udp_rx_parser #(
    .NUM_PORTS (NP),
    .MAX_LEN   (MAXL)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .valid_i        (valid),
    .din_i          (din),
    .promisc_i      (promisc),
    .listen_en_i    (listen_en),
    .listen_ports_i (listen_ports),
    .source_o       (source),
    .dest_o         (dest),
    .length_o       (length),
    .checksum_o     (checksum),
    .hdr_done_o     (hdr_done),
    .port_hit_o     (port_hit),
    .port_idx_o     (port_idx),
    .pl_valid_o     (pl_valid),
    .pl_data_o      (pl_data),
    .pl_first_o     (pl_first),
    .pl_last_o      (pl_last),
    .done_o         (done),
    .err_o          (err),
    .err_code_o     (err_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0]  data;
    logic        first;
    logic        last;
    logic        dn;
    logic [31:0] cyc;
  } beat_t;

  beat_t got_pl[$];
  beat_t exp_pl[$];
  int    got_hdr = 0, got_done = 0, got_co = 0, got_stray = 0;
  int    exp_hdr = 0, exp_done = 0, exp_co = 0;
  logic [31:0] got_hdr_cyc = '0, exp_hdr_cyc = '0;
  logic        exp_err, exp_hit, exp_fld;
  logic [1:0]  exp_code, exp_idx;
  logic [15:0] exp_src, exp_dst, exp_len, exp_csum;

  logic [7:0] fr[$];

  // Observer: records output events; comparisons happen in the main sequence.
  always @(negedge clk) begin
    if (pl_valid) got_pl.push_back({pl_data, pl_first, pl_last, done, cyc});
    else if (pl_first || pl_last) got_stray++;
    if (hdr_done) begin
      got_hdr++;
      got_hdr_cyc = cyc;
    end
    if (done) got_done++;
    if (done && hdr_done) got_co++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check($sformatf("%s fields", tag), 64'({source, dest, length, checksum}), 64'(0));
    check($sformatf("%s flags", tag),
          64'({hdr_done, port_hit, port_idx, pl_valid, pl_data, pl_first, pl_last,
               done, err, err_code}), 64'(0));
  endtask

  task automatic build(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                       input logic [15:0] c, input int npay);
    fr.delete();
    fr.push_back(s[15:8]); fr.push_back(s[7:0]);
    fr.push_back(d[15:8]); fr.push_back(d[7:0]);
    fr.push_back(l[15:8]); fr.push_back(l[7:0]);
    fr.push_back(c[15:8]); fr.push_back(c[7:0]);
    for (int k = 0; k < npay; k++) fr.push_back(8'($urandom));
  endtask

  // Drives fr as one frame (valid low one cycle afterwards) and appends the
  // expected outcome computed from the frame-level rules.
  task automatic send_frame();
    int unsigned acc[$];
    int          n, pay, avail, m, idx;
    logic        found;
    logic [15:0] d, l;
    beat_t       b;
    n = fr.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      valid = 1'b1;
      din   = fr[k];
      acc.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    din   = 8'($urandom);

    if (n < 8) begin
      exp_done++;
      exp_err  = 1'b1;
      exp_code = 2'd3;
      exp_hit  = 1'b0;
      exp_idx  = 2'd0;
      exp_fld  = 1'b0;
    end else begin
      d = {fr[2], fr[3]};
      l = {fr[4], fr[5]};
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NP; i++) begin
        if (!found && listen_en[i] && listen_ports[16*i +: 16] == d) begin
          found = 1'b1;
          idx   = i;
        end
      end
      exp_hdr++;
      exp_hdr_cyc = acc[7];
      exp_hit  = promisc || found;
      exp_idx  = 2'(idx);
      exp_src  = {fr[0], fr[1]};
      exp_dst  = d;
      exp_len  = l;
      exp_csum = {fr[6], fr[7]};
      exp_fld  = 1'b1;
      exp_err  = 1'b0;
      exp_code = 2'd0;
      if (l < 8 || l > MAXL) begin
        exp_done++;
        exp_co++;
        exp_err  = 1'b1;
        exp_code = 2'd1;
      end else if (l == 8) begin
        exp_done++;
        exp_co++;
      end else if (exp_hit) begin
        pay   = int'(l) - 8;
        avail = n - 8;
        m     = (avail < pay) ? avail : pay;
        for (int j = 0; j < m; j++) begin
          b = {fr[8+j], (j == 0), (j == pay - 1), (j == pay - 1), acc[8+j]};
          exp_pl.push_back(b);
        end
        exp_done++;
        if (avail < pay) begin
          exp_err  = 1'b1;
          exp_code = 2'd2;
        end
      end
    end
  endtask

  task automatic check_frame(input string tag);
    int k;
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s hdr_done count", tag), 64'(got_hdr), 64'(exp_hdr));
    if (exp_hdr > 0)
      check($sformatf("%s hdr_done cycle", tag), 64'(got_hdr_cyc), 64'(exp_hdr_cyc));
    check($sformatf("%s done count", tag), 64'(got_done), 64'(exp_done));
    check($sformatf("%s done with hdr_done", tag), 64'(got_co), 64'(exp_co));
    check($sformatf("%s stray first/last", tag), 64'(got_stray), 64'(0));
    check($sformatf("%s payload beats", tag), 64'(got_pl.size()), 64'(exp_pl.size()));
    k = (got_pl.size() < exp_pl.size()) ? got_pl.size() : exp_pl.size();
    for (int i = 0; i < k; i++)
      check($sformatf("%s beat %0d {data,first,last,done,cyc}", tag, i),
            64'(got_pl[i]), 64'(exp_pl[i]));
    check($sformatf("%s err", tag), 64'(err), 64'(exp_err));
    check($sformatf("%s err_code", tag), 64'(err_code), 64'(exp_code));
    check($sformatf("%s port_hit", tag), 64'(port_hit), 64'(exp_hit));
    check($sformatf("%s port_idx", tag), 64'(port_idx), 64'(exp_idx));
    if (exp_fld) begin
      check($sformatf("%s source", tag), 64'(source), 64'(exp_src));
      check($sformatf("%s dest", tag), 64'(dest), 64'(exp_dst));
      check($sformatf("%s length", tag), 64'(length), 64'(exp_len));
      check($sformatf("%s checksum", tag), 64'(checksum), 64'(exp_csum));
    end
    got_pl.delete();
    exp_pl.delete();
    got_hdr = 0; got_done = 0; got_co = 0; got_stray = 0;
    exp_hdr = 0; exp_done = 0; exp_co = 0;
  endtask

  function automatic logic [15:0] pick_port();
    case ($urandom_range(0, 3))
      0:       return 16'h0050;
      1:       return 16'h0051;
      2:       return 16'h0777;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic push_dead_beef();
    fr.push_back(8'hDE); fr.push_back(8'hAD); fr.push_back(8'hBE); fr.push_back(8'hEF);
  endtask

  int          kind, np, nkeep, pay;
  logic [15:0] rd, rl;

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #11 check_outputs_zero("reset");
    #5 rst_n = 1'b1;

    listen_ports = {16'h4444, 16'h0050, 16'h2222, 16'h1111};
    listen_en    = 4'b0100;
    promisc      = 1'b0;

    // Basic frame, entry 2 matches
    build(16'h1234, 16'h0050, 16'h000C, 16'hBEEF, 0);
    push_dead_beef();
    send_frame();
    check_frame("basic");

    // Padding discarded, back-to-back frame after a 1-cycle gap
    build(16'h1234, 16'h0050, 16'h000C, 16'hBEEF, 0);
    push_dead_beef();
    for (int k = 0; k < 6; k++) fr.push_back(8'($urandom));
    send_frame();
    build(16'hA5A5, 16'h0050, 16'h000C, 16'h1357, 4);
    send_frame();
    check_frame("padding+b2b");

    // No match, then promiscuous
    build(16'h1234, 16'h0051, 16'h000C, 16'hBEEF, 4);
    send_frame();
    check_frame("nohit");
    promisc = 1'b1;
    send_frame();
    check_frame("promisc");
    promisc = 1'b0;

    // Lowest enabled index wins; disabled entry 0 ignored
    listen_ports = {16'h0777, 16'h0050, 16'h0777, 16'h0777};
    listen_en    = 4'b1110;
    build(16'h0001, 16'h0777, 16'h000A, 16'h0000, 2);
    send_frame();
    check_frame("priority");
    listen_ports = {16'h4444, 16'h0050, 16'h2222, 16'h1111};
    listen_en    = 4'b0100;

    // Length boundaries
    build(16'h0001, 16'h0050, 16'h0004, 16'h0000, 4);
    send_frame();
    check_frame("len4");
    build(16'h0002, 16'h0050, 16'h0008, 16'h0000, 0);
    send_frame();
    check_frame("len8");
    build(16'h0003, 16'h0050, 16'h0008, 16'h0000, 3);
    send_frame();
    check_frame("len8 padded");
    build(16'h0004, 16'h0050, 16'(MAXL), 16'h0000, MAXL - 8);
    send_frame();
    check_frame("len max");
    build(16'h0005, 16'h0050, 16'(MAXL + 1), 16'h0000, 4);
    send_frame();
    check_frame("len max+1");

    // Truncations
    build(16'h1234, 16'h0050, 16'h000C, 16'hBEEF, 0);
    while (fr.size() > 6) void'(fr.pop_back());
    send_frame();
    check_frame("hdr trunc");
    build(16'h1234, 16'h0050, 16'h0010, 16'hBEEF, 3);
    send_frame();
    check_frame("payload trunc");
    build(16'h1234, 16'h0050, 16'h0010, 16'hBEEF, 0);
    send_frame();
    check_frame("payload trunc0");

    // Reset during payload byte 2
    build(16'h0102, 16'h0050, 16'h0010, 16'h0000, 5);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      valid = 1'b1;
      din   = fr[k];
    end
    @(posedge clk); #1;
    din = fr[10];
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async reset");
    valid = 1'b0;
    got_pl.delete();
    got_hdr = 0; got_done = 0; got_co = 0; got_stray = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post-reset payload beats", 64'(got_pl.size()), 64'(0));
    check("post-reset done count", 64'(got_done), 64'(0));
    check_outputs_zero("post-reset");
    build(16'h1234, 16'h0050, 16'h000C, 16'hBEEF, 0);
    push_dead_beef();
    send_frame();
    check_frame("after reset");

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      listen_en = 4'($urandom);
      for (int i = 0; i < NP; i++) listen_ports[16*i +: 16] = pick_port();
      promisc = ($urandom_range(0, 3) == 0);
      rd      = pick_port();
      kind    = $urandom_range(0, 9);
      if (kind == 0) begin
        rl = 16'($urandom_range(0, 7));
        np = $urandom_range(0, 4);
      end else if (kind == 1) begin
        rl = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'(MAXL + 1 + $urandom_range(0, 2000));
        np = 2;
      end else if (kind == 2) begin
        rl = 16'($urandom_range(8, MAXL));
        np = 0;
      end else if (kind == 3) begin
        rl  = 16'($urandom_range(9, MAXL));
        pay = int'(rl) - 8;
        np  = $urandom_range(0, pay - 1);
      end else begin
        rl  = 16'($urandom_range(8, MAXL));
        pay = int'(rl) - 8;
        np  = pay + $urandom_range(0, 5);
      end
      build(16'($urandom), rd, rl, 16'($urandom), np);
      if (kind == 2) begin
        nkeep = $urandom_range(1, 7);
        while (fr.size() > nkeep) void'(fr.pop_back());
      end
      send_frame();
      check_frame($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
